// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : pc_fetch_sequencer
// Description: Selects the PC register's next value and runs the imem fetch
//              handshake, squashing fetches made stale by a redirect.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h003FFFFC,
   parameter logic [31:0] EXC_VEC   = 32'h00400080,
   parameter int unsigned MAX_WAIT  = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_cur,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        exc_req,
   input  logic        imem_ready,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic        fetch_valid,
   output logic        fetch_timeout
);

   localparam logic [7:0]  c_MAX_WAIT  = 8'(MAX_WAIT);
   localparam logic [31:0] c_ALIGN     = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      S_BOOT   = 2'd0,
      S_FETCH  = 2'd1,
      S_SQUASH = 2'd2
   } state_t;

   state_t      r_state,      w_state_nxt;
   logic [7:0]  r_wait_cnt,   w_wait_nxt;
   logic        r_pend_valid, w_pend_valid_nxt;
   logic [31:0] r_pend_tgt,   w_pend_tgt_nxt;
   logic [1:0]  r_pend_pri,   w_pend_pri_nxt;

   logic [31:0] w_sel;
   logic [1:0]  w_pri;
   logic        w_redirect;
   logic        w_latch;
   logic [31:0] w_pc_inc;

   // Priority code: 3 = exception, 2 = jump, 1 = branch, 0 = none
   always_comb begin
      w_sel = pc_cur;
      w_pri = 2'd0;
      if (exc_req) begin
         w_sel = EXC_VEC & c_ALIGN;
         w_pri = 2'd3;
      end else if (jump) begin
         w_sel = jump_target & c_ALIGN;
         w_pri = 2'd2;
      end else if (branch_taken) begin
         w_sel = branch_target & c_ALIGN;
         w_pri = 2'd1;
      end
   end

   assign w_redirect = exc_req | jump | branch_taken;
   // A pending redirect is only displaced by one of equal or higher priority.
   assign w_latch    = w_redirect && (!r_pend_valid || (w_pri >= r_pend_pri));
   assign w_pc_inc   = pc_cur + 32'd4;
   assign imem_addr  = pc_cur;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_BOOT;
         r_wait_cnt   <= 8'd0;
         r_pend_valid <= 1'b0;
         r_pend_tgt   <= 32'd0;
         r_pend_pri   <= 2'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_wait_cnt   <= w_wait_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_pend_tgt   <= w_pend_tgt_nxt;
         r_pend_pri   <= w_pend_pri_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_wait_nxt       = r_wait_cnt;
      w_pend_valid_nxt = r_pend_valid;
      w_pend_tgt_nxt   = r_pend_tgt;
      w_pend_pri_nxt   = r_pend_pri;
      pc_next          = pc_cur;
      imem_req         = 1'b0;
      fetch_valid      = 1'b0;
      fetch_timeout    = 1'b0;

      case (r_state)
         S_BOOT: begin
            pc_next     = RESET_VEC;
            w_state_nxt = S_FETCH;
         end

         S_FETCH: begin
            imem_req = 1'b1;
            if (!imem_ready) begin
               if (r_wait_cnt == c_MAX_WAIT) begin
                  fetch_timeout    = 1'b1;
                  w_pend_valid_nxt = 1'b1;
                  w_pend_tgt_nxt   = EXC_VEC & c_ALIGN;
                  w_pend_pri_nxt   = 2'd3;
                  w_state_nxt      = S_SQUASH;
               end else begin
                  w_wait_nxt = r_wait_cnt + 8'd1;
                  if (w_latch) begin
                     w_pend_valid_nxt = 1'b1;
                     w_pend_tgt_nxt   = w_sel;
                     w_pend_pri_nxt   = w_pri;
                  end
               end
            end else if (stall) begin
               // Same address is refetched once the stall clears.
               w_wait_nxt = 8'd0;
               if (w_latch) begin
                  w_pend_valid_nxt = 1'b1;
                  w_pend_tgt_nxt   = w_sel;
                  w_pend_pri_nxt   = w_pri;
               end
            end else begin
               w_wait_nxt       = 8'd0;
               w_pend_valid_nxt = 1'b0;
               fetch_valid      = !r_pend_valid;
               if (r_pend_valid)
                  pc_next = r_pend_tgt;
               else if (w_redirect)
                  pc_next = w_sel;
               else
                  pc_next = w_pc_inc;
            end
         end

         S_SQUASH: begin
            pc_next          = r_pend_tgt;
            w_pend_valid_nxt = 1'b0;
            w_wait_nxt       = 8'd0;
            w_state_nxt      = S_FETCH;
         end

         default: begin
            pc_next     = RESET_VEC;
            w_state_nxt = S_BOOT;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : tb_pc_fetch_sequencer
// Description: Directed vector bench for pc_fetch_sequencer with a PC register model.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

   localparam logic [31:0] c_RESET_VEC = 32'h003FFFFC;
   localparam logic [31:0] c_EXC_VEC   = 32'h00400080;
   localparam int          c_NV        = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_cur;
   logic        stall, branch_taken, jump, exc_req, imem_ready;
   logic [31:0] branch_target, jump_target;
   logic [31:0] pc_next, imem_addr;
   logic        imem_req, fetch_valid, fetch_timeout;

   logic [31:0] r_pc;
   logic        ovr_en;
   logic [31:0] ovr_pc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] bt;
      logic        jmp;
      logic [31:0] jt;
      logic        exc;
      logic        rdy;
      logic [31:0] e_next;
      logic        e_req;
      logic        e_fv;
   } vec_t;

   vec_t vecs [c_NV];

   always #5 clk = ~clk;

   // PC register: loads pc_next every edge, async reset to the boot vector
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_pc <= c_RESET_VEC;
      else       r_pc <= pc_next;
   end

   assign pc_cur = ovr_en ? ovr_pc : r_pc;

   pc_fetch_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .pc_cur        (pc_cur),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .exc_req       (exc_req),
      .imem_ready    (imem_ready),
      .pc_next       (pc_next),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .fetch_valid   (fetch_valid),
      .fetch_timeout (fetch_timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                        input logic jmp, input logic [31:0] jt, input logic exc,
                        input logic rdy);
      stall = st; branch_taken = br; branch_target = bt;
      jump = jmp; jump_target = jt; exc_req = exc; imem_ready = rdy;
   endtask

   task automatic set_vec(input int i, input logic st, input logic br, input logic [31:0] bt,
                          input logic jmp, input logic [31:0] jt, input logic exc,
                          input logic rdy, input logic [31:0] en, input logic er,
                          input logic ef);
      vecs[i].stall = st; vecs[i].br = br; vecs[i].bt = bt;
      vecs[i].jmp = jmp; vecs[i].jt = jt; vecs[i].exc = exc; vecs[i].rdy = rdy;
      vecs[i].e_next = en; vecs[i].e_req = er; vecs[i].e_fv = ef;
   endtask

   initial begin
      //         st br bt            jmp jt            exc rdy next          req fv
      set_vec( 0, 0, 0, 32'h0,        0, 32'h0,         0, 1, 32'h003FFFFC, 0, 0); // BOOT
      set_vec( 1, 0, 0, 32'h0,        0, 32'h0,         0, 1, 32'h00400000, 1, 1);
      set_vec( 2, 0, 0, 32'h0,        0, 32'h0,         0, 1, 32'h00400004, 1, 1);
      set_vec( 3, 0, 0, 32'h0,        0, 32'h0,         0, 0, 32'h00400004, 1, 0);
      set_vec( 4, 0, 0, 32'h0,        0, 32'h0,         0, 0, 32'h00400004, 1, 0);
      set_vec( 5, 0, 0, 32'h0,        0, 32'h0,         0, 0, 32'h00400004, 1, 0);
      set_vec( 6, 0, 0, 32'h0,        0, 32'h0,         0, 1, 32'h00400008, 1, 1);
      set_vec( 7, 0, 1, 32'h00400100, 0, 32'h0,         0, 0, 32'h00400008, 1, 0);
      set_vec( 8, 0, 0, 32'h0,        0, 32'h0,         0, 1, 32'h00400100, 1, 0);
      set_vec( 9, 0, 1, 32'h00600000, 1, 32'h00500000,  1, 1, c_EXC_VEC,    1, 1);
      set_vec(10, 0, 0, 32'h0,        1, 32'h00400013,  0, 1, 32'h00400010, 1, 1);
      set_vec(11, 1, 1, 32'h00400200, 0, 32'h0,         0, 1, 32'h00400010, 1, 0);
      set_vec(12, 0, 0, 32'h0,        0, 32'h0,         0, 1, 32'h00400200, 1, 0);
      set_vec(13, 1, 0, 32'h0,        0, 32'h0,         0, 1, 32'h00400200, 1, 0);
      set_vec(14, 0, 0, 32'h0,        0, 32'h0,         0, 1, 32'h00400204, 1, 1);

      ovr_en = 1'b0; ovr_pc = 32'd0;
      reset  = 1'b1;
      drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("rst_pc_next", pc_next, c_RESET_VEC);
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      check("rst_timeout", {31'd0, fetch_timeout}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < c_NV; i++) begin
         drive(vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt,
               vecs[i].exc, vecs[i].rdy);
         #1;
         check($sformatf("v%0d_pc_next", i), pc_next, vecs[i].e_next);
         check($sformatf("v%0d_imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
         check($sformatf("v%0d_fetch_valid", i), {31'd0, fetch_valid}, {31'd0, vecs[i].e_fv});
         check($sformatf("v%0d_timeout", i), {31'd0, fetch_timeout}, 32'd0);
         check($sformatf("v%0d_imem_addr", i), imem_addr, r_pc);
         @(negedge clk);
      end

      // Timeout: 16 wait cycles, pulse on the 16th, then SQUASH to the handler
      for (int k = 1; k <= 16; k++) begin
         drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
         #1;
         check($sformatf("to%0d_timeout", k), {31'd0, fetch_timeout}, (k == 16) ? 32'd1 : 32'd0);
         check($sformatf("to%0d_pc_next", k), pc_next, 32'h00400204);
         check($sformatf("to%0d_imem_req", k), {31'd0, imem_req}, 32'd1);
         @(negedge clk);
      end
      #1;
      check("sq_imem_req", {31'd0, imem_req}, 32'd0);
      check("sq_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      check("sq_timeout", {31'd0, fetch_timeout}, 32'd0);
      check("sq_pc_next", pc_next, c_EXC_VEC);
      @(negedge clk);
      drive(0, 0, 32'h0, 0, 32'h0, 0, 1);
      #1;
      check("post_sq_pc_next", pc_next, 32'h00400084);
      check("post_sq_fetch_valid", {31'd0, fetch_valid}, 32'd1);

      // Reset asserted mid-wait takes effect without a clock edge
      @(negedge clk);
      drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check("mid_rst_pc_next", pc_next, c_RESET_VEC);
      check("mid_rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("mid_rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      check("mid_rst_timeout", {31'd0, fetch_timeout}, 32'd0);
      imem_ready = 1'b1;
      @(posedge clk); #1;
      check("rst_rdy_pc_next", pc_next, c_RESET_VEC);
      check("rst_rdy_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("boot2_imem_req", {31'd0, imem_req}, 32'd0);
      check("boot2_pc_next", pc_next, c_RESET_VEC);

      // PC wrap: FFFFFFFC + 4 -> 00000000
      @(negedge clk);
      ovr_pc = 32'hFFFFFFFC; ovr_en = 1'b1;
      #1;
      check("wrap_pc_next", pc_next, 32'h00000000);
      check("wrap_fetch_valid", {31'd0, fetch_valid}, 32'd1);
      check("wrap_imem_addr", imem_addr, 32'hFFFFFFFC);
      ovr_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
